mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage; the receiving end of the EXE->MEM bus and of the data-SRAM read path.
//  Accepts {pc, gr_we, dest, alu_result, res_from_mem} from EXE, merges synchronous SRAM read data,
//  and hands {pc, gr_we, dest, final_result} to WB. Drives the MEM forwarding bus back to ID.
//  Holds load data while stalled, because the SRAM output follows whatever address EXE drives next.
// PARAMETERS
//  ES_MS_BUS_W   71  EXE->MEM bus width: pc[70:39] gr_we[38] dest[37:33] alu_result[32:1] res_from_mem[0]
//  MS_WS_BUS_W   69  MEM->WB bus width: pc[68:37] gr_we[36] dest[36-1:32] final_result[31:0]
//  FWD_BUS_W     38  forward bus: we_valid[37] dest[36:32] result[31:0]
// PORTS
//  clk              in   1    clock
//  reset            in   1    synchronous, active-high reset
//  es_to_ms_valid   in   1    EXE holds a valid instruction for MEM
//  ms_allow_in      out  1    MEM can accept this cycle
//  es_ms_bus        in   71   EXE->MEM payload (layout above)
//  data_sram_rdata  in   32   SRAM read data; valid in the first cycle the load sits in MEM
//  ws_allow_in      in   1    WB can accept this cycle
//  ms_to_ws_valid   out  1    MEM presents a valid instruction to WB
//  ms_ws_bus        out  69   MEM->WB payload (layout above)
//  ms_fwd_bus       out  38   {ms_gr_we & ms_valid, ms_dest, final_result}
// BEHAVIOUR
//  - Reset: ms_valid=0, ms_first=0, rbuf_valid=0, payload regs=0.
//    ms_to_ws_valid=0, ms_allow_in=1, ms_fwd_bus[37]=0.
//  - ms_ready_go=1 (no internal wait); ms_allow_in = !ms_valid | (ms_ready_go & ws_allow_in).
//    ms_to_ws_valid = ms_valid & ms_ready_go.
//  - ms_valid <= es_to_ms_valid when ms_allow_in; otherwise holds.
//    Payload latches only on es_to_ms_valid & ms_allow_in.
//  - ms_first: set on every accept, cleared the first cycle no accept occurs. It marks the cycle
//    in which data_sram_rdata belongs to the resident instruction.
//  - rdata hold: when ms_first & ms_valid & !ws_allow_in, capture data_sram_rdata into rbuf and set rbuf_valid.
//    rbuf_valid clears on the next accept. A cleared ms_valid alone does not clear rbuf_valid.
//  - mem_data = rbuf_valid ? rbuf : data_sram_rdata.
//    final_result = res_from_mem ? mem_data : alu_result (full 32-bit word, no extension).
//  - Latency: one cycle EXE->MEM register; MEM->WB is combinational from MEM registers.
//    A non-stalled load produces final_result in its first MEM cycle.
//  - Back-to-back accepts: rbuf_valid clears in the same edge that loads the new payload.
//    A new instruction never sees stale buffered data.
//  - Stall >1 cycle: rbuf is written only in the ms_first cycle. Later SRAM changes are ignored.
//  - Bubble (es_to_ms_valid=0 while ms_allow_in=1): ms_valid->0 and fwd valid->0. Payload regs hold.
//  - Reset asserted mid-stall: all state returns to reset values on that edge. The held load is dropped.
//  - Forwarding: ms_fwd_bus[37] is never 1 while ms_valid=0. For a load, result[31:0] equals mem_data.
// STRUCTURE
//  - Shared package/header (mycpu_defs): bus widths, field MSB/LSB constants for es_ms/ms_ws/fwd buses.
//  - One natural sub-module: ms_rdata_hold (ms_first, rbuf, rbuf_valid; ins: accept, stall, rdata).
//  - Pipeline valid/allow_in logic and final_result mux stay in mem_stage.
// TESTING
//  1. Reset held 2 cycles -> ms_to_ws_valid=0, ms_allow_in=1, ms_fwd_bus[37]=0.
//  2. ALU op: pc=0x1c000010, dest=5, gr_we=1, alu_result=0x12345678, res_from_mem=0, ws_allow_in=1
//     -> next cycle ms_ws_bus final_result=0x12345678, dest=5, fwd[37]=1.
//  3. Load, no stall: res_from_mem=1, rdata=0xdeadbeef in first MEM cycle -> final_result=0xdeadbeef same cycle.
//  4. Load stalled: ws_allow_in=0 for 3 cycles; rdata 0xdeadbeef then 0x0, 0x55aa55aa
//     -> final_result stays 0xdeadbeef all 3 cycles, ms_allow_in=0.
//  5. Stalled load then accept of ALU op (alu_result=0x7) -> rbuf_valid=0, final_result=0x7.
//  6. Reset asserted during test-4 stall -> next cycle ms_valid=0, fwd[37]=0, ms_allow_in=1.
//     A new load then returns live rdata.

Source files
------------

// File: rtl/mycpu_defs.sv
// Shared bus widths and field positions for the EXE->MEM, MEM->WB and
// MEM forwarding buses.
package mycpu_defs;

    localparam int ES_MS_BUS_W = 71;
    localparam int MS_WS_BUS_W = 69;
    localparam int FWD_BUS_W   = 38;

    localparam int ES_PC_MSB   = 70;
    localparam int ES_PC_LSB   = 39;
    localparam int ES_WE_BIT   = 38;
    localparam int ES_DEST_MSB = 37;
    localparam int ES_DEST_LSB = 33;
    localparam int ES_ALU_MSB  = 32;
    localparam int ES_ALU_LSB  = 1;
    localparam int ES_RFM_BIT  = 0;

    // WB dest field is only four bits wide in this bus layout
    localparam int WS_PC_MSB   = 68;
    localparam int WS_PC_LSB   = 37;
    localparam int WS_WE_BIT   = 36;
    localparam int WS_DEST_MSB = 35;
    localparam int WS_DEST_LSB = 32;
    localparam int WS_RES_MSB  = 31;

    localparam int FWD_WE_BIT   = 37;
    localparam int FWD_DEST_MSB = 36;
    localparam int FWD_DEST_LSB = 32;
    localparam int FWD_RES_MSB  = 31;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        res_from_mem;
    } es_ms_t;

endpackage

// File: rtl/ms_rdata_hold.sv
// Captures SRAM load data in the first MEM cycle of a stalled instruction
// so later address changes from EXE cannot corrupt it.
module ms_rdata_hold
    import mycpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept_i,
    input  logic        stall_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] mem_data_o
);

    logic        first_q;
    logic        first_d;
    logic        rbuf_valid_q;
    logic        rbuf_valid_d;
    logic [31:0] rbuf_q;
    logic [31:0] rbuf_d;

    always_comb begin
        first_d      = accept_i;
        rbuf_valid_d = rbuf_valid_q;
        rbuf_d       = rbuf_q;
        if (accept_i) begin
            rbuf_valid_d = 1'b0;
        end else if (first_q && stall_i) begin
            rbuf_valid_d = 1'b1;
            rbuf_d       = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_q      <= 1'b0;
            rbuf_valid_q <= 1'b0;
            rbuf_q       <= '0;
        end else begin
            first_q      <= first_d;
            rbuf_valid_q <= rbuf_valid_d;
            rbuf_q       <= rbuf_d;
        end
    end

    assign mem_data_o = rbuf_valid_q ? rbuf_q : rdata_i;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EXE payload, merges SRAM
// read data and drives the WB bus plus the MEM forwarding bus.
module mem_stage
    import mycpu_defs::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es_to_ms_valid,
    output logic                   ms_allow_in,
    input  logic [ES_MS_BUS_W-1:0] es_ms_bus,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allow_in,
    output logic                   ms_to_ws_valid,
    output logic [MS_WS_BUS_W-1:0] ms_ws_bus,
    output logic [FWD_BUS_W-1:0]   ms_fwd_bus
);

    es_ms_t      es_in;
    es_ms_t      pl_q;
    es_ms_t      pl_d;
    logic        ms_valid_q;
    logic        ms_valid_d;
    logic        ms_ready_go;
    logic        accept;
    logic        stall;
    logic [31:0] mem_data;
    logic [31:0] final_result;

    assign es_in.pc           = es_ms_bus[ES_PC_MSB:ES_PC_LSB];
    assign es_in.gr_we        = es_ms_bus[ES_WE_BIT];
    assign es_in.dest         = es_ms_bus[ES_DEST_MSB:ES_DEST_LSB];
    assign es_in.alu_result   = es_ms_bus[ES_ALU_MSB:ES_ALU_LSB];
    assign es_in.res_from_mem = es_ms_bus[ES_RFM_BIT];

    assign ms_ready_go    = 1'b1;
    assign ms_allow_in    = !ms_valid_q || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allow_in;
    assign stall          = ms_valid_q && !ws_allow_in;

    always_comb begin
        ms_valid_d = ms_valid_q;
        pl_d       = pl_q;
        if (ms_allow_in) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (accept) begin
            pl_d = es_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            pl_q       <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            pl_q       <= pl_d;
        end
    end

    ms_rdata_hold u_hold (
        .clk        (clk),
        .reset      (reset),
        .accept_i   (accept),
        .stall_i    (stall),
        .rdata_i    (data_sram_rdata),
        .mem_data_o (mem_data)
    );

    assign final_result = pl_q.res_from_mem ? mem_data : pl_q.alu_result;

    always_comb begin
        ms_ws_bus = '0;
        ms_ws_bus[WS_PC_MSB:WS_PC_LSB]     = pl_q.pc;
        ms_ws_bus[WS_WE_BIT]               = pl_q.gr_we;
        ms_ws_bus[WS_DEST_MSB:WS_DEST_LSB] = pl_q.dest[3:0];
        ms_ws_bus[WS_RES_MSB:0]            = final_result;
    end

    always_comb begin
        ms_fwd_bus = '0;
        ms_fwd_bus[FWD_WE_BIT]                = pl_q.gr_we && ms_valid_q;
        ms_fwd_bus[FWD_DEST_MSB:FWD_DEST_LSB] = pl_q.dest;
        ms_fwd_bus[FWD_RES_MSB:0]             = final_result;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// run against a residency-based reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allow_in;
    logic [70:0] es_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ws_allow_in;
    logic        ms_to_ws_valid;
    logic [68:0] ms_ws_bus;
    logic [37:0] ms_fwd_bus;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allow_in     (ms_allow_in),
        .es_ms_bus       (es_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ws_allow_in     (ws_allow_in),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_ws_bus       (ms_ws_bus),
        .ms_fwd_bus      (ms_fwd_bus)
    );

    function automatic logic [70:0] mk(input logic [31:0] pc,
                                       input logic we,
                                       input logic [4:0] dest,
                                       input logic [31:0] alu,
                                       input logic rfm);
        return {pc, we, dest, alu, rfm};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        total_cnt++;
        if (ms_to_ws_valid !== 1'b0)
            $display("FAIL reset_valid got %0b exp 0", ms_to_ws_valid);
        else pass_cnt++;
        total_cnt++;
        if (ms_allow_in !== 1'b1)
            $display("FAIL reset_allow got %0b exp 1", ms_allow_in);
        else pass_cnt++;
        total_cnt++;
        if (ms_fwd_bus[37] !== 1'b0)
            $display("FAIL reset_fwd got %0b exp 0", ms_fwd_bus[37]);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        es_to_ms_valid = 1'b1;
        es_ms_bus = mk(32'h1c000010, 1'b1, 5'd5, 32'h12345678, 1'b0);
        ws_allow_in = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = $urandom;
        #1;
        total_cnt++;
        if (ms_ws_bus[31:0] !== 32'h12345678)
            $display("FAIL alu_result got %h exp 12345678", ms_ws_bus[31:0]);
        else pass_cnt++;
        total_cnt++;
        if (ms_ws_bus[35:32] !== 4'd5)
            $display("FAIL alu_dest got %0d exp 5", ms_ws_bus[35:32]);
        else pass_cnt++;
        total_cnt++;
        if (ms_ws_bus[68:37] !== 32'h1c000010)
            $display("FAIL alu_pc got %h exp 1c000010", ms_ws_bus[68:37]);
        else pass_cnt++;
        total_cnt++;
        if (ms_fwd_bus[37:32] !== {1'b1, 5'd5})
            $display("FAIL alu_fwd got %h exp 25", ms_fwd_bus[37:32]);
        else pass_cnt++;
        total_cnt++;
        if (ms_to_ws_valid !== 1'b1)
            $display("FAIL alu_valid got %0b exp 1", ms_to_ws_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_nostall();
        es_to_ms_valid = 1'b1;
        es_ms_bus = mk(32'h1c000014, 1'b1, 5'd6, 32'h100, 1'b1);
        ws_allow_in = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'hdeadbeef;
        #1;
        total_cnt++;
        if (ms_ws_bus[31:0] !== 32'hdeadbeef)
            $display("FAIL ld_result got %h exp deadbeef", ms_ws_bus[31:0]);
        else pass_cnt++;
        total_cnt++;
        if (ms_fwd_bus[31:0] !== 32'hdeadbeef)
            $display("FAIL ld_fwd got %h exp deadbeef", ms_fwd_bus[31:0]);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({ms_to_ws_valid, ms_fwd_bus[37]} !== 2'b00)
            $display("FAIL bubble got %b exp 00",
                     {ms_to_ws_valid, ms_fwd_bus[37]});
        else pass_cnt++;
    endtask

    task automatic test_load_stall();
        logic [31:0] seq [3];
        seq[0] = 32'hdeadbeef;
        seq[1] = 32'h0;
        seq[2] = 32'h55aa55aa;
        es_to_ms_valid = 1'b1;
        es_ms_bus = mk(32'h1c000018, 1'b1, 5'd7, 32'h200, 1'b1);
        ws_allow_in = 1'b1;
        tick();
        ws_allow_in = 1'b0;
        es_ms_bus = mk(32'h1c00001c, 1'b1, 5'd9, 32'hbad, 1'b0);
        for (int i = 0; i < 3; i++) begin
            data_sram_rdata = seq[i];
            #1;
            total_cnt++;
            if (ms_ws_bus[31:0] !== 32'hdeadbeef)
                $display("FAIL stall_result[%0d] got %h exp deadbeef",
                         i, ms_ws_bus[31:0]);
            else pass_cnt++;
            total_cnt++;
            if (ms_allow_in !== 1'b0)
                $display("FAIL stall_allow[%0d] got %0b exp 0",
                         i, ms_allow_in);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        ws_allow_in = 1'b1;
        es_to_ms_valid = 1'b1;
        es_ms_bus = mk(32'h1c000020, 1'b1, 5'd8, 32'h7, 1'b0);
        data_sram_rdata = 32'h11111111;
        #1;
        total_cnt++;
        if (ms_ws_bus[31:0] !== 32'hdeadbeef || ms_allow_in !== 1'b1)
            $display("FAIL release got %h/%0b exp deadbeef/1",
                     ms_ws_bus[31:0], ms_allow_in);
        else pass_cnt++;
        tick();
        es_ms_bus = mk(32'h1c000024, 1'b1, 5'd10, 32'h300, 1'b1);
        #1;
        total_cnt++;
        if (ms_ws_bus[31:0] !== 32'h7)
            $display("FAIL b2b_alu got %h exp 7", ms_ws_bus[31:0]);
        else pass_cnt++;
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h0badf00d;
        #1;
        total_cnt++;
        if (ms_ws_bus[31:0] !== 32'h0badf00d)
            $display("FAIL b2b_load got %h exp 0badf00d", ms_ws_bus[31:0]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        es_to_ms_valid = 1'b1;
        es_ms_bus = mk(32'h1c000028, 1'b1, 5'd11, 32'h400, 1'b1);
        ws_allow_in = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        ws_allow_in = 1'b0;
        data_sram_rdata = 32'hdeadbeef;
        tick();
        data_sram_rdata = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (ms_to_ws_valid !== 1'b0 || ms_fwd_bus[37] !== 1'b0)
            $display("FAIL rst_stall_valid got %b exp 00",
                     {ms_to_ws_valid, ms_fwd_bus[37]});
        else pass_cnt++;
        total_cnt++;
        if (ms_allow_in !== 1'b1)
            $display("FAIL rst_stall_allow got %0b exp 1", ms_allow_in);
        else pass_cnt++;
        es_to_ms_valid = 1'b1;
        ws_allow_in = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h13579bdf;
        #1;
        total_cnt++;
        if (ms_ws_bus[31:0] !== 32'h13579bdf)
            $display("FAIL rst_new_load got %h exp 13579bdf",
                     ms_ws_bus[31:0]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        logic        m_valid;
        logic [31:0] m_pc;
        logic        m_we;
        logic [4:0]  m_dest;
        logic [31:0] m_alu;
        logic        m_rfm;
        int          m_age;
        logic [31:0] m_hold;
        logic [31:0] exp_res;
        logic        exp_allow;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_valid = 1'b0;
        m_pc = '0;
        m_we = 1'b0;
        m_dest = '0;
        m_alu = '0;
        m_rfm = 1'b0;
        m_age = 0;
        m_hold = '0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            es_to_ms_valid = ($urandom_range(0, 9) < 7);
            ws_allow_in = ($urandom_range(0, 9) < 6);
            es_ms_bus = mk($urandom, 1'($urandom), 5'($urandom),
                           $urandom, 1'($urandom));
            data_sram_rdata = $urandom;
            #1;
            exp_allow = !m_valid || ws_allow_in;
            total_cnt++;
            if (ms_allow_in !== exp_allow)
                $display("FAIL rnd_allow[%0d] got %0b exp %0b",
                         n, ms_allow_in, exp_allow);
            else pass_cnt++;
            total_cnt++;
            if (ms_to_ws_valid !== m_valid ||
                ms_fwd_bus[37] !== (m_valid && m_we))
                $display("FAIL rnd_valid[%0d] got %b exp %b", n,
                         {ms_to_ws_valid, ms_fwd_bus[37]},
                         {m_valid, m_valid && m_we});
            else pass_cnt++;
            if (m_valid) begin
                if (!m_rfm) exp_res = m_alu;
                else if (m_age == 0) exp_res = data_sram_rdata;
                else exp_res = m_hold;
                total_cnt++;
                if (ms_ws_bus !== {m_pc, m_we, m_dest[3:0], exp_res})
                    $display("FAIL rnd_ws[%0d] got %h exp %h", n, ms_ws_bus,
                             {m_pc, m_we, m_dest[3:0], exp_res});
                else pass_cnt++;
                total_cnt++;
                if (ms_fwd_bus[36:0] !== {m_dest, exp_res})
                    $display("FAIL rnd_fwd[%0d] got %h exp %h", n,
                             ms_fwd_bus[36:0], {m_dest, exp_res});
                else pass_cnt++;
            end
            if (reset) begin
                m_valid = 1'b0;
            end else if (exp_allow) begin
                m_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    {m_pc, m_we, m_dest, m_alu, m_rfm} = es_ms_bus;
                    m_age = 0;
                end
            end else begin
                if (m_age == 0) m_hold = data_sram_rdata;
                m_age++;
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_ms_bus = '0;
        data_sram_rdata = '0;
        ws_allow_in = 1'b1;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load_nostall();
        test_load_stall();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
